pipelined_adder: RTL and testbench

PIPELINED_ADDER -- requirements
Module: pipelined_adder

---
 rtl/pipelined_adder_pkg.sv | 14 +
 rtl/pipelined_adder_stage.sv | 46 ++++
 rtl/pipelined_adder.sv | 137 +++++++++++++
 tb/tb_pipelined_adder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_adder_pkg.sv
// Shared constants and helpers for the pipelined adder.
// The optional overflow output is enabled by defining PIPELINED_ADDER_OVF_EN.
package pipelined_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH  = 32;
    localparam int unsigned DEFAULT_STAGES = 4;

    // Bits handled by each pipeline stage; guards against a zero stage count.
    function automatic int unsigned chunk_width(input int unsigned width,
                                                input int unsigned stages);
        return (stages == 0) ? width : width / stages;
    endfunction

endpackage

// File: rtl/pipelined_adder_stage.sv
// One pipeline stage: adds a CW-bit operand chunk plus carry-in and registers
// the chunk sum, chunk carry and the stage valid bit when enabled.
module pipelined_adder_stage
    import pipelined_adder_pkg::*;
#(
    parameter int unsigned CW = chunk_width(DEFAULT_WIDTH, DEFAULT_STAGES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic          valid_i,
    input  logic [CW-1:0] a_i,
    input  logic [CW-1:0] b_i,
    input  logic          carry_i,
    output logic          valid_o,
    output logic [CW-1:0] sum_o,
    output logic          carry_o
);

    logic          valid_q;
    logic [CW-1:0] sum_q;
    logic [CW-1:0] sum_d;
    logic          carry_q;
    logic          carry_d;

    always_comb begin
        {carry_d, sum_d} = {1'b0, a_i} + {1'b0, b_i} + {{CW{1'b0}}, carry_i};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else if (en_i) begin
            valid_q <= valid_i;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign valid_o = valid_q;
    assign sum_o   = sum_q;
    assign carry_o = carry_q;

endmodule

// File: rtl/pipelined_adder.sv
// Carry-pipelined adder: STAGES chunks of WIDTH/STAGES bits, valid/ready flow
// control. Define PIPELINED_ADDER_OVF_EN to add the signed-overflow output ovf.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPELINED_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = chunk_width(WIDTH, STAGES);

    if ((STAGES == 0) ? 1'b1 : ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a multiple of STAGES and STAGES >= 1");
    end

    logic            adv;
    logic [STAGES:0] valid_p;
    logic [STAGES:0] carry_p;

    // The whole pipeline moves in lockstep; a stalled output freezes every stage.
    assign in_ready   = !out_valid || out_ready;
    assign adv        = in_ready;
    assign valid_p[0] = in_valid;
    assign carry_p[0] = cin;
    assign out_valid  = valid_p[STAGES];
    assign cout       = carry_p[STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_chunk
        localparam int unsigned AD = k;
        localparam int unsigned HD = STAGES - 1 - k;

        logic [CW-1:0] a_k;
        logic [CW-1:0] b_k;
        logic [CW-1:0] s_k;

        // Chunk k of the operands waits k cycles so it meets its carry.
        if (AD == 0) begin : g_direct
            assign a_k = a[CW-1:0];
            assign b_k = b[CW-1:0];
        end else begin : g_delay
            logic [CW-1:0] a_dq [AD];
            logic [CW-1:0] b_dq [AD];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int unsigned i = 0; i < AD; i++) begin
                        a_dq[i] <= '0;
                        b_dq[i] <= '0;
                    end
                end else if (adv) begin
                    a_dq[0] <= a[k*CW +: CW];
                    b_dq[0] <= b[k*CW +: CW];
                    for (int unsigned i = 1; i < AD; i++) begin
                        a_dq[i] <= a_dq[i-1];
                        b_dq[i] <= b_dq[i-1];
                    end
                end
            end

            assign a_k = a_dq[AD-1];
            assign b_k = b_dq[AD-1];
        end

        pipelined_adder_stage #(
            .CW(CW)
        ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .en_i   (adv),
            .valid_i(valid_p[k]),
            .a_i    (a_k),
            .b_i    (b_k),
            .carry_i(carry_p[k]),
            .valid_o(valid_p[k+1]),
            .sum_o  (s_k),
            .carry_o(carry_p[k+1])
        );

        // Finished low chunks are held until the top chunk catches up.
        if (HD == 0) begin : g_out
            assign sum[k*CW +: CW] = s_k;
        end else begin : g_hold
            logic [CW-1:0] s_dq [HD];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int unsigned i = 0; i < HD; i++) begin
                        s_dq[i] <= '0;
                    end
                end else if (adv) begin
                    s_dq[0] <= s_k;
                    for (int unsigned i = 1; i < HD; i++) begin
                        s_dq[i] <= s_dq[i-1];
                    end
                end
            end

            assign sum[k*CW +: CW] = s_dq[HD-1];
        end

`ifdef PIPELINED_ADDER_OVF_EN
        if (HD == 0) begin : g_ovf
            logic a_msb_q;
            logic b_msb_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_msb_q <= 1'b0;
                    b_msb_q <= 1'b0;
                end else if (adv) begin
                    a_msb_q <= a_k[CW-1];
                    b_msb_q <= b_k[CW-1];
                end
            end

            assign ovf = (a_msb_q == b_msb_q) && (sum[WIDTH-1] != a_msb_q);
        end
`endif
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and random checks of pipelined_adder (32/4 and 3/3 instances).
// Define PIPELINED_ADDER_OVF_EN to also check the ovf output.
module tb_pipelined_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, cin, out_valid, out_ready, cout;
    logic [31:0] a, b, sum;
    logic        in_valid3, in_ready3, cin3, out_valid3, out_ready3, cout3;
    logic [2:0]  a3, b3, sum3;
`ifdef PIPELINED_ADDER_OVF_EN
    logic        ovf, ovf3;
`endif

    pipelined_adder #(.WIDTH(32), .STAGES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
`ifdef PIPELINED_ADDER_OVF_EN
        , .ovf(ovf)
`endif
    );

    pipelined_adder #(.WIDTH(3), .STAGES(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
        .a(a3), .b(b3), .cin(cin3), .out_valid(out_valid3), .out_ready(out_ready3),
        .sum(sum3), .cout(cout3)
`ifdef PIPELINED_ADDER_OVF_EN
        , .ovf(ovf3)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    int          n_out;
    logic        last_acc;
    logic [33:0] expq [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {ovf, cout, sum}
    function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y, input logic c);
        logic [32:0] s;
        logic        o;
        s = {1'b0, x} + {1'b0, y} + {32'd0, c};
        o = (x[31] == y[31]) && (s[31] != x[31]);
        return {o, s};
    endfunction

    // One clock cycle on the 32-bit DUT with scoreboard checking of any output transfer.
    task automatic step(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                        input logic ic, input logic ordy);
        logic [33:0] e;
        @(negedge clk);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        cin       = ic;
        out_ready = ordy;
        #1;
        if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
                check("stale_out", {63'd0, out_valid}, 64'd0);
            end else begin
                e = expq.pop_front();
                check("res_sum", {32'd0, sum}, {32'd0, e[31:0]});
                check("res_cout", {63'd0, cout}, {63'd0, e[32]});
`ifdef PIPELINED_ADDER_OVF_EN
                check("res_ovf", {63'd0, ovf}, {63'd0, e[33]});
`endif
                n_out++;
            end
        end
        last_acc = in_valid && in_ready;
        if (last_acc) expq.push_back(model(ia, ib, ic));
    endtask

    task automatic single32(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                            input logic ic, input logic [31:0] es, input logic ec, input logic eo);
        int lat;
        @(negedge clk);
        in_valid = 1'b1; a = ia; b = ib; cin = ic; out_ready = 1'b1;
        #1 check({tag, "_rdy"}, {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
            #1;
        end while (!out_valid && lat < 20);
        check({tag, "_lat"}, 64'(lat), 64'd4);
        check({tag, "_sum"}, {32'd0, sum}, {32'd0, es});
        check({tag, "_cout"}, {63'd0, cout}, {63'd0, ec});
`ifdef PIPELINED_ADDER_OVF_EN
        check({tag, "_ovf"}, {63'd0, ovf}, {63'd0, eo});
`else
        if (eo) begin end
`endif
    endtask

    task automatic single3(input string tag, input logic [2:0] ia, input logic [2:0] ib, input logic ic);
        int         lat;
        logic [2:0] es;
        logic       c;
        c = ic;
        for (int i = 0; i < 3; i++) begin
            es[i] = ia[i] ^ ib[i] ^ c;
            c     = (ia[i] & ib[i]) | (ia[i] & c) | (ib[i] & c);
        end
        @(negedge clk);
        in_valid3 = 1'b1; a3 = ia; b3 = ib; cin3 = ic;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            in_valid3 = 1'b0;
            lat++;
            #1;
        end while (!out_valid3 && lat < 20);
        check({tag, "_lat"}, 64'(lat), 64'd3);
        check({tag, "_sum"}, {61'd0, sum3}, {61'd0, es});
        check({tag, "_cout"}, {63'd0, cout3}, {63'd0, c});
    endtask

    logic [31:0] sa [6];
    logic [31:0] sb [6];
    logic [31:0] held_sum;
    logic        held_cout;
    logic        seen;
    int          guard;

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
        in_valid3 = 1'b0; a3 = '0; b3 = '0; cin3 = 1'b0; out_ready3 = 1'b1;
        n_out = 0;
        last_acc = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_sum", {32'd0, sum}, 64'd0);
        check("rst_cout", {63'd0, cout}, 64'd0);
        check("rst_out_valid3", {63'd0, out_valid3}, 64'd0);
        rst = 1'b0;
        #1 check("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Directed 32-bit vectors
        single32("ones_p1",  32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        single32("carry24",  32'h00FF_FFFF, 32'h0000_0001, 1'b0, 32'h0100_0000, 1'b0, 1'b0);
        single32("plain",    32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0);
        single32("negneg",   32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
        single32("allones",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        single32("mid16",    32'h0000_FFFF, 32'h0000_FFFF, 1'b1, 32'h0001_FFFF, 1'b0, 1'b0);
        single32("ovf_pos",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        single32("wrap",     32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);

        // 3-bit, one bit per chunk: every full-adder input combination
        for (int i = 0; i < 8; i++) begin
            logic [2:0] iv;
            iv = 3'(i);
            single3($sformatf("fa%0d", i), {3{iv[0]}}, {3{iv[1]}}, iv[2]);
        end
        single3("fa_ones_p1", 3'b111, 3'b001, 1'b0);
        single3("fa_mixed", 3'b101, 3'b011, 1'b1);

        // Back-to-back with a three-cycle output stall
        sa[0] = 32'h0000_0001; sb[0] = 32'h0000_0002;
        sa[1] = 32'hFFFF_FFFF; sb[1] = 32'h0000_0001;
        sa[2] = 32'h7FFF_FFFF; sb[2] = 32'h7FFF_FFFF;
        sa[3] = 32'h0F0F_0F0F; sb[3] = 32'hF0F0_F0F0;
        sa[4] = 32'hDEAD_BEEF; sb[4] = 32'h1234_5678;
        sa[5] = 32'h00FF_00FF; sb[5] = 32'h00FF_FF01;
        expq.delete();
        n_out = 0;
        for (int k = 0; k < 5; k++) step(1'b1, sa[k], sb[k], 1'b0, 1'b1);
        check("stall_first_out", 64'(n_out), 64'd1);
        step(1'b1, sa[5], sb[5], 1'b0, 1'b0);
        held_sum  = sum;
        held_cout = cout;
        check("stall_in_ready0", {63'd0, in_ready}, 64'd0);
        check("stall_sum_val", {32'd0, held_sum}, {32'd0, 32'h0000_0000});
        check("stall_cout_val", {63'd0, held_cout}, 64'd1);
        for (int s = 0; s < 2; s++) begin
            step(1'b1, sa[5], sb[5], 1'b0, 1'b0);
            check("stall_in_ready", {63'd0, in_ready}, 64'd0);
            check("stall_out_valid", {63'd0, out_valid}, 64'd1);
            check("stall_sum_hold", {32'd0, sum}, {32'd0, held_sum});
            check("stall_cout_hold", {63'd0, cout}, {63'd0, held_cout});
        end
        guard = 0;
        do begin
            step(1'b1, sa[5], sb[5], 1'b0, 1'b1);
            guard++;
        end while (!last_acc && guard < 20);
        guard = 0;
        while (n_out < 6 && guard < 20) begin
            step(1'b0, '0, '0, 1'b0, 1'b1);
            guard++;
        end
        check("stall_count", 64'(n_out), 64'd6);

        // Reset with three transactions in flight
        for (int k = 0; k < 3; k++) step(1'b1, sa[k], sb[k], 1'b1, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        expq.delete();
        #1;
        check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_sum", {32'd0, sum}, 64'd0);
        check("mid_rst_cout", {63'd0, cout}, 64'd0);
        check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(1'b0, '0, '0, 1'b0, 1'b1);
            seen = seen | out_valid;
        end
        check("mid_rst_no_result", {63'd0, seen}, 64'd0);
        single32("after_rst", 32'h0000_0005, 32'h0000_0006, 1'b0, 32'h0000_000B, 1'b0, 1'b0);

        // Random traffic against the reference model
        expq.delete();
        n_out = 0;
        for (int k = 0; k < 10000; k++) begin
            step(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0));
        end
        guard = 0;
        while (expq.size() != 0 && guard < 50) begin
            step(1'b0, '0, '0, 1'b0, 1'b1);
            guard++;
        end
        check("rand_drain", 64'(expq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
